eth_key_extract: RTL and testbench
==================================

ETH_KEY_EXTRACT -- requirements
Module: eth_key_extract

Interface
REQ-001 Parameter KEY_SIZE, default 96, key width; only 96 is supported.
REQ-002 clk156  in  1  156.25 MHz Ethernet core clock; all logic on rising edge.
REQ-003 eth_rst  in  1  synchronous, active-high reset.
REQ-004 s_axis_rx_tvalid  in  1  MAC RX beat valid; no tready, so every valid beat is consumed.
REQ-005 s_axis_rx_tdata  in  64  frame bytes; byte n of a beat on bits [8n+7:8n].
REQ-006 s_axis_rx_tkeep  in  8  byte enables; contiguous from bit 0, all-ones on non-last beats.
REQ-007 s_axis_rx_tlast  in  1  last beat of frame.
REQ-008 s_axis_rx_tuser  in  1  frame-good flag on the tlast beat (1 = good).
REQ-009 in_key  out  96  {src IPv4, dst IPv4, src port, dst port}, network byte order, src IP in [95:64].
REQ-010 in_flag  out  4  4'b0001 = TCP, 4'b0010 = UDP; other codes are never produced.
REQ-011 in_valid  out  1  one-cycle pulse qualifying in_key and in_flag.
REQ-012 stat_rx_frames  out  32  count of complete frames seen (tlast beats).
REQ-013 stat_key_frames  out  32  count of in_valid pulses.

Function
REQ-014 A per-frame byte offset counter shall advance by 8 on each valid beat, reset to 0 after a tlast beat.
REQ-015 The FSM shall have these states and transitions:
- SYNC: after reset, discard beats; go to IDLE after the first tlast beat.
- IDLE: any valid beat is beat 0; go to HDR, or stay in IDLE if it also carries tlast.
- HDR: capture header fields by byte offset; go to WAIT_LAST once the last key byte is captured.
- WAIT_LAST: consume beats until tlast, then return to IDLE.
REQ-016 Qualification checks (untagged frame), all of which must hold:
- ethertype bytes 12-13 = 0x0800;
- byte 14 = 0x45;
- flags/fragment offset bytes 20-21, with the DF bit masked, = 0;
- protocol byte 23 = 6 (TCP) or 17 (UDP).
REQ-017 Key byte offsets shall be: src IP at 26-29, dst IP at 30-33, src port at 34-35, dst port at 36-37.
REQ-018 in_valid shall assert exactly one cycle after the tlast beat, only if all of the following hold:
- the frame is qualified;
- all key bytes were received with their tkeep bits set;
- tuser = 1 on the tlast beat.
REQ-019 If tlast arrives in HDR before all key bytes are captured, the frame shall be discarded, the FSM shall return to IDLE, and no in_valid shall be produced.
REQ-020 in_key and in_flag shall be registered and shall hold their values until the next in_valid.
REQ-021 Back-to-back frames (tlast followed by beat 0 on the next cycle) shall be handled with no lost beat.
REQ-022 tvalid low mid-frame shall stall the FSM and the counter; no timeout.
REQ-023 stat_rx_frames shall increment on every tlast beat outside SYNC, including errored frames; stat_key_frames shall increment with in_valid; both counters wrap from 0xFFFFFFFF to 0.

Reset
REQ-024 On eth_rst, outputs shall reset as follows:
- FSM to SYNC;
- byte counter to 0;
- in_valid = 0, in_key = 0, in_flag = 0;
- both counters = 0.
REQ-025 Reset asserted mid-frame shall abort the frame with no in_valid; the remaining beats are discarded in SYNC.

Configuration
REQ-026 Macro ETH_KEY_EXTRACT_VLAN_EN controls single 802.1Q tag support.
- Defined: a frame with bytes 12-13 = 0x8100 shall be treated as tagged. All fields from REQ-016/017 shift by +4 bytes (ethertype 16-17, dst port 40-41), and the key completes on beat 5.
- Undefined: a frame with bytes 12-13 = 0x8100 shall be unqualified.

Verification
REQ-027 UDP frame, 10.0.0.1:1234 -> 10.0.0.2:80, 64 bytes, tuser = 1:
- in_valid pulses one cycle after tlast;
- in_key = 0x0A000001_0A000002_04D2_0050;
- in_flag = 4'b0010.
REQ-028 Same frame as TCP with tuser = 0 on tlast: no in_valid; stat_rx_frames +1; stat_key_frames unchanged.
REQ-029 ARP frame (0x0806), then an IPv4 frame with byte 14 = 0x46, then a fragment with MF = 1: no in_valid for any; stat_rx_frames = 3.
REQ-030 Two UDP frames back-to-back with tvalid gaps inserted mid-header: two in_valid pulses with the correct distinct keys.
REQ-031 eth_rst pulsed at beat 2 of a frame: no in_valid for that frame. The next complete frame is also dropped (SYNC). The frame after that yields in_valid.
REQ-032 With ETH_KEY_EXTRACT_VLAN_EN defined, VLAN-tagged UDP frame (VID 5) with the REQ-027 tuple: same in_key as REQ-027. With the macro undefined: no in_valid.

Source files
------------

// File: rtl/eth_key_extract.sv
// IPv4 TCP/UDP tuple extractor on the MAC RX stream; in_valid one cycle after a qualifying tlast, no backpressure (every beat consumed).
// Single 802.1Q tag support when ETH_KEY_EXTRACT_VLAN_EN is defined.
module eth_key_extract #(
  parameter int KEY_SIZE = 96
) (
  input  logic                clk156,
  input  logic                eth_rst,
  input  logic                s_axis_rx_tvalid,
  input  logic [63:0]         s_axis_rx_tdata,
  input  logic [7:0]          s_axis_rx_tkeep,
  input  logic                s_axis_rx_tlast,
  input  logic                s_axis_rx_tuser,
  output logic [KEY_SIZE-1:0] in_key,
  output logic [3:0]          in_flag,
  output logic                in_valid,
  output logic [31:0]         stat_rx_frames,
  output logic [31:0]         stat_key_frames
);

`ifdef ETH_KEY_EXTRACT_VLAN_EN
  localparam int HDR_BEATS = 6;
`else
  localparam int HDR_BEATS = 5;
`endif
  localparam int HDR_BYTES = HDR_BEATS * 8;

  typedef enum logic [1:0] {SYNC, IDLE, HDR, WAIT_LAST} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             off_q, off_d;
  logic [HDR_BYTES*8-1:0]  hdr_q, hw;
  logic [HDR_BYTES-1:0]    kv_q, kv_w;
  logic                    vld_q, vld_d;
  logic [KEY_SIZE-1:0]     key_q, key_d, key_w;
  logic [3:0]              flag_q, flag_d;
  logic [31:0]             rx_q, rx_d, kf_q, kf_d;

  logic [12:0]             beat_idx, last_beat;
  logic                    wr_en;
  int unsigned             sh;
  logic [15:0]             ethtype, frag;
  logic [7:0]              ver_ihl, proto;
  logic                    is_tcp, is_udp, qual, keys_ok, fire;

  function automatic logic [7:0] hb(input logic [HDR_BYTES*8-1:0] v, input int unsigned i);
    return v[8*i +: 8];
  endfunction

  assign beat_idx = off_q[15:3];
  assign wr_en    = s_axis_rx_tvalid && (state_q == IDLE || state_q == HDR);

  // Header view including the beat being accepted this cycle, so a frame
  // ending on its key-completing beat can still be judged at tlast.
  always_comb begin
    hw   = hdr_q;
    kv_w = (state_q == IDLE) ? '0 : kv_q;
    for (int b = 0; b < HDR_BEATS; b++) begin
      if (wr_en && beat_idx == 13'(b)) begin
        hw[64*b +: 64] = s_axis_rx_tdata;
        kv_w[8*b +: 8] = s_axis_rx_tkeep;
      end
    end
  end

  always_comb begin
    sh = 0;
`ifdef ETH_KEY_EXTRACT_VLAN_EN
    if ({hb(hw, 12), hb(hw, 13)} == 16'h8100) sh = 4;
`endif
    ethtype   = {hb(hw, 12 + sh), hb(hw, 13 + sh)};
    ver_ihl   = hb(hw, 14 + sh);
    frag      = {hb(hw, 20 + sh), hb(hw, 21 + sh)};
    proto     = hb(hw, 23 + sh);
    is_tcp    = (proto == 8'd6);
    is_udp    = (proto == 8'd17);
    // DF (0x4000) is allowed; MF or any fragment offset disqualifies.
    qual      = (ethtype == 16'h0800) && (ver_ihl == 8'h45) &&
                ((frag & 16'hBFFF) == 16'h0000) && (is_tcp || is_udp);
    keys_ok   = &kv_w[12 + sh +: 26];
    last_beat = (sh == 0) ? 13'd4 : 13'd5;
    key_w     = '0;
    for (int k = 0; k < 12; k++) begin
      key_w[KEY_SIZE-1-8*k -: 8] = hb(hw, 26 + sh + k);
    end
  end

  assign fire = s_axis_rx_tvalid && s_axis_rx_tlast && s_axis_rx_tuser &&
                (state_q == HDR || state_q == WAIT_LAST) && qual && keys_ok;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    vld_d   = 1'b0;
    key_d   = key_q;
    flag_d  = flag_q;
    rx_d    = rx_q;
    kf_d    = kf_q;
    if (s_axis_rx_tvalid) begin
      off_d = s_axis_rx_tlast ? 16'd0 : off_q + 16'd8;
      unique case (state_q)
        SYNC:      if (s_axis_rx_tlast) state_d = IDLE;
        IDLE:      if (!s_axis_rx_tlast) state_d = HDR;
        HDR: begin
          if (s_axis_rx_tlast)             state_d = IDLE;
          else if (beat_idx == last_beat)  state_d = WAIT_LAST;
        end
        WAIT_LAST: if (s_axis_rx_tlast) state_d = IDLE;
        default:   state_d = SYNC;
      endcase
      if (s_axis_rx_tlast && state_q != SYNC) rx_d = rx_q + 32'd1;
      if (fire) begin
        vld_d  = 1'b1;
        key_d  = key_w;
        flag_d = is_tcp ? 4'b0001 : 4'b0010;
        kf_d   = kf_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state_q <= SYNC;
      off_q   <= '0;
      kv_q    <= '0;
      vld_q   <= 1'b0;
      key_q   <= '0;
      flag_q  <= '0;
      rx_q    <= '0;
      kf_q    <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      kv_q    <= kv_w;
      vld_q   <= vld_d;
      key_q   <= key_d;
      flag_q  <= flag_d;
      rx_q    <= rx_d;
      kf_q    <= kf_d;
    end
  end

  always_ff @(posedge clk156) begin
    hdr_q <= hw;
  end

  assign in_valid        = vld_q;
  assign in_key          = key_q;
  assign in_flag         = flag_q;
  assign stat_rx_frames  = rx_q;
  assign stat_key_frames = kf_q;

endmodule

// File: tb/tb_eth_key_extract.sv
// Directed-frame bench for eth_key_extract with a frame-level reference model.
module tb_eth_key_extract;
  logic        clk156 = 1'b0;
  logic        eth_rst;
  logic        tvalid;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic [95:0] in_key;
  logic [3:0]  in_flag;
  logic        in_valid;
  logic [31:0] stat_rx_frames;
  logic [31:0] stat_key_frames;

  always #5 clk156 = ~clk156;

  eth_key_extract #(.KEY_SIZE(96)) dut (
    .clk156          (clk156),
    .eth_rst         (eth_rst),
    .s_axis_rx_tvalid(tvalid),
    .s_axis_rx_tdata (tdata),
    .s_axis_rx_tkeep (tkeep),
    .s_axis_rx_tlast (tlast),
    .s_axis_rx_tuser (tuser),
    .in_key          (in_key),
    .in_flag         (in_flag),
    .in_valid        (in_valid),
    .stat_rx_frames  (stat_rx_frames),
    .stat_key_frames (stat_key_frames)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: reassembles each frame as a byte list and applies the
  // qualification rules at byte offsets.
  logic [7:0]  mf[$];
  bit          m_sync;
  bit          m_vld;
  logic [95:0] m_key;
  logic [3:0]  m_flag;
  logic [31:0] m_rx, m_kf;

  task automatic eval_frame();
    int n  = mf.size();
    int sh = 0;
    bit ok;
    logic [7:0] pr;
    pr = 8'h00;
`ifdef ETH_KEY_EXTRACT_VLAN_EN
    if (n >= 14 && mf[12] == 8'h81 && mf[13] == 8'h00) sh = 4;
`endif
    ok = (tuser == 1'b1) && (n >= 38 + sh);
    if (ok) begin
      pr = mf[23+sh];
      ok = (mf[12+sh] == 8'h08) && (mf[13+sh] == 8'h00) && (mf[14+sh] == 8'h45) &&
           ((mf[20+sh] & 8'hBF) == 8'h00) && (mf[21+sh] == 8'h00) &&
           (pr == 8'd6 || pr == 8'd17);
    end
    if (ok) begin
      m_vld  = 1'b1;
      m_kf   = m_kf + 1;
      m_flag = (pr == 8'd6) ? 4'b0001 : 4'b0010;
      for (int k = 0; k < 12; k++) m_key = {m_key[87:0], mf[26+sh+k]};
    end
  endtask

  always @(posedge clk156) begin
    m_vld = 1'b0;
    if (eth_rst) begin
      mf.delete();
      m_sync = 1'b1;
      m_key  = '0;
      m_flag = '0;
      m_rx   = '0;
      m_kf   = '0;
    end else if (tvalid) begin
      for (int k = 0; k < 8; k++) if (tkeep[k]) mf.push_back(tdata[8*k +: 8]);
      if (tlast) begin
        if (m_sync) m_sync = 1'b0;
        else begin
          m_rx = m_rx + 1;
          eval_frame();
        end
        mf.delete();
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk156) begin
    if (cmp_en) begin
      chk("cyc_in_valid", {95'd0, in_valid}, {95'd0, m_vld});
      chk("cyc_in_key", in_key, m_key);
      chk("cyc_in_flag", {92'd0, in_flag}, {92'd0, m_flag});
      chk("cyc_stat_rx", {64'd0, stat_rx_frames}, {64'd0, m_rx});
      chk("cyc_stat_key", {64'd0, stat_key_frames}, {64'd0, m_kf});
    end
  end

  logic [7:0] frm[$];

  task automatic build(input logic [15:0] etype, input bit vlan, input logic [7:0] vihl,
                       input logic [15:0] frag, input logic [7:0] pr,
                       input logic [31:0] sip, input logic [31:0] dip,
                       input logic [15:0] sp, input logic [15:0] dp, input int len);
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back((i == 5) ? 8'h01 : 8'h02);
    for (int i = 0; i < 6; i++) frm.push_back((i == 5) ? 8'h02 : 8'h04);
    if (vlan) begin
      frm.push_back(8'h81); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h05);
    end
    frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
    frm.push_back(vihl); frm.push_back(8'h00);
    frm.push_back(8'h00); frm.push_back(8'h32);
    frm.push_back(8'h12); frm.push_back(8'h34);
    frm.push_back(frag[15:8]); frm.push_back(frag[7:0]);
    frm.push_back(8'h40); frm.push_back(pr);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int k = 3; k >= 0; k--) frm.push_back(sip[8*k +: 8]);
    for (int k = 3; k >= 0; k--) frm.push_back(dip[8*k +: 8]);
    frm.push_back(sp[15:8]); frm.push_back(sp[7:0]);
    frm.push_back(dp[15:8]); frm.push_back(dp[7:0]);
    while (frm.size() < len) frm.push_back(8'hA5);
    while (frm.size() > len) void'(frm.pop_back());
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk156); #1;
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tkeep = '0; tdata = '0;
    end
  endtask

  task automatic send_frame(input bit good, input int gap_beat, input int rst_beat);
    int n  = frm.size();
    int nb = (n + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      if (b == gap_beat) idle(2);
      @(posedge clk156); #1;
      tvalid = 1'b1; tdata = '0; tkeep = '0;
      for (int k = 0; k < 8; k++) begin
        if (b*8 + k < n) begin
          tdata[8*k +: 8] = frm[b*8 + k];
          tkeep[k] = 1'b1;
        end
      end
      tlast = (b == nb - 1);
      tuser = (b == nb - 1) ? good : 1'b0;
      if (b == rst_beat) begin
        eth_rst = 1'b1;
        @(posedge clk156); #1;
        eth_rst = 1'b0; tvalid = 1'b0; tlast = 1'b0; tkeep = '0;
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk156); #1;
    eth_rst = 1'b1; tvalid = 1'b0; tlast = 1'b0;
    @(posedge clk156); #1;
    eth_rst = 1'b0;
  endtask

  localparam logic [95:0] K027 = 96'h0A000001_0A000002_04D2_0050;
  localparam logic [95:0] K030B = 96'hC0A8010B_C0A80115_2711_0035;

  initial begin
    eth_rst = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tuser = 1'b0;
    repeat (3) @(posedge clk156);
    #1 eth_rst = 1'b0;
    @(negedge clk156);
    chk("rst_in_valid", {95'd0, in_valid}, 96'd0);
    chk("rst_in_key", in_key, 96'd0);
    chk("rst_in_flag", {92'd0, in_flag}, 96'd0);
    chk("rst_stat_rx", {64'd0, stat_rx_frames}, 96'd0);
    chk("rst_stat_key", {64'd0, stat_key_frames}, 96'd0);
    cmp_en = 1'b1;

    // First frame after reset is swallowed while synchronising.
    build(16'h0800, 0, 8'h45, 16'h0000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 64);
    send_frame(1, -1, -1); idle(1);
    @(negedge clk156);
    chk("sync_in_valid", {95'd0, in_valid}, 96'd0);
    chk("sync_stat_rx", {64'd0, stat_rx_frames}, 96'd0);

    build(16'h0800, 0, 8'h45, 16'h0000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 64);
    send_frame(1, -1, -1); idle(1);
    @(negedge clk156);
    chk("udp_in_valid", {95'd0, in_valid}, 96'd1);
    chk("udp_in_key", in_key, K027);
    chk("udp_in_flag", {92'd0, in_flag}, 96'd2);
    idle(2);

    build(16'h0800, 0, 8'h45, 16'h0000, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 64);
    send_frame(0, -1, -1); idle(1);
    @(negedge clk156);
    chk("bad_in_valid", {95'd0, in_valid}, 96'd0);
    chk("bad_stat_rx", {64'd0, stat_rx_frames}, 96'd2);
    chk("bad_stat_key", {64'd0, stat_key_frames}, 96'd1);
    chk("bad_key_held", in_key, K027);

    do_reset();
    build(16'h0806, 0, 8'h45, 16'h0000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1, 16'd2, 64);
    send_frame(1, -1, -1); idle(1);
    send_frame(1, -1, -1); idle(1);
    build(16'h0800, 0, 8'h46, 16'h0000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1, 16'd2, 64);
    send_frame(1, -1, -1); idle(1);
    build(16'h0800, 0, 8'h45, 16'h2000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1, 16'd2, 64);
    send_frame(1, -1, -1); idle(1);
    @(negedge clk156);
    chk("unq_stat_rx", {64'd0, stat_rx_frames}, 96'd3);
    chk("unq_stat_key", {64'd0, stat_key_frames}, 96'd0);

    // DF alone must not disqualify.
    build(16'h0800, 0, 8'h45, 16'h4000, 8'd6, 32'hC0A80001, 32'hC0A80002, 16'd8080, 16'd443, 64);
    send_frame(1, -1, -1); idle(1);
    @(negedge clk156);
    chk("df_in_valid", {95'd0, in_valid}, 96'd1);
    chk("df_in_flag", {92'd0, in_flag}, 96'd1);

    build(16'h0800, 0, 8'h45, 16'h0000, 8'd17, 32'hC0A8010A, 32'hC0A80114, 16'd5000, 16'd53, 64);
    send_frame(1, 2, -1);
    build(16'h0800, 0, 8'h45, 16'h0000, 8'd17, 32'hC0A8010B, 32'hC0A80115, 16'd10001, 16'd53, 72);
    send_frame(1, 3, -1); idle(1);
    @(negedge clk156);
    chk("b2b_in_valid", {95'd0, in_valid}, 96'd1);
    chk("b2b_in_key", in_key, K030B);
    chk("b2b_stat_key", {64'd0, stat_key_frames}, 96'd3);
    idle(2);

    build(16'h0800, 0, 8'h45, 16'h0000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 64);
    send_frame(1, -1, 2); idle(2);
    send_frame(1, -1, -1); idle(1);
    @(negedge clk156);
    chk("rst_mid_in_valid", {95'd0, in_valid}, 96'd0);
    chk("rst_mid_stat_rx", {64'd0, stat_rx_frames}, 96'd0);
    send_frame(1, -1, -1); idle(1);
    @(negedge clk156);
    chk("rst_after_in_valid", {95'd0, in_valid}, 96'd1);
    chk("rst_after_stat_rx", {64'd0, stat_rx_frames}, 96'd1);

    build(16'h8100, 1, 8'h45, 16'h0000, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 68);
    send_frame(1, -1, -1); idle(1);
    @(negedge clk156);
`ifdef ETH_KEY_EXTRACT_VLAN_EN
    chk("vlan_in_valid", {95'd0, in_valid}, 96'd1);
    chk("vlan_in_key", in_key, K027);
`else
    chk("vlan_in_valid", {95'd0, in_valid}, 96'd0);
`endif

    // Truncated header: tlast before the destination port arrives.
    build(16'h0800, 0, 8'h45, 16'h0000, 8'd17, 32'h01020304, 32'h05060708, 16'd9, 16'd10, 30);
    send_frame(1, -1, -1); idle(1);
    @(negedge clk156);
    chk("trunc_in_valid", {95'd0, in_valid}, 96'd0);

    // Exactly 38 bytes: the key completes on the tlast beat.
    build(16'h0800, 0, 8'h45, 16'h0000, 8'd17, 32'h01020304, 32'h05060708, 16'd9, 16'd10, 38);
    send_frame(1, -1, -1); idle(1);
    @(negedge clk156);
    chk("min_in_valid", {95'd0, in_valid}, 96'd1);
    chk("min_in_key", in_key, 96'h01020304_05060708_0009_000A);

    build(16'h0800, 0, 8'h45, 16'h0000, 8'd1, 32'h01020304, 32'h05060708, 16'd9, 16'd10, 64);
    send_frame(1, -1, -1);
    build(16'h0800, 0, 8'h45, 16'h0000, 8'd17, 32'h01020304, 32'h05060708, 16'd9, 16'd10, 8);
    send_frame(1, -1, -1); idle(1);
    @(negedge clk156);
    chk("short_in_valid", {95'd0, in_valid}, 96'd0);
    idle(3);

    @(negedge clk156);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
